// File: rtl/countdown_bank.sv
// Bank of N countdown channels sharing a prescaler tick; sticky expiry flags with OR'd irq.
// Strobes take effect on the next edge; rdata and irq are combinational; no backpressure.
module countdown_bank #(
    parameter int W = 8,
    parameter int N = 4,
    parameter int P = 8,
    parameter int S = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [P-1:0] div,
    input  logic [S-1:0] sel,
    input  logic [W-1:0] value,
    input  logic         put,
    input  logic         cfg,
    input  logic [1:0]   mode_in,
    input  logic         ack,
    output logic [W-1:0] rdata,
    output logic [N-1:0] flags,
    output logic         irq
);

    logic [P-1:0] pre_q, pre_d;
    logic [W-1:0] count_q  [N];
    logic [W-1:0] count_d  [N];
    logic [W-1:0] reload_q [N];
    logic [W-1:0] reload_d [N];
    logic [N-1:0] en_q, en_d;
    logic [N-1:0] per_q, per_d;
    logic [N-1:0] flag_q, flag_d;

    logic         tick;
    logic         sel_ok;
    logic [N-1:0] hit;
    logic [N-1:0] expire;

    assign sel_ok = (int'(sel) < N);
    assign tick   = (pre_q == '0);

    always_comb begin
        pre_d  = tick ? div : pre_q - P'(1);
        en_d   = en_q;
        per_d  = per_q;
        flag_d = flag_q;
        hit    = '0;
        expire = '0;
        for (int i = 0; i < N; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            hit[i]      = sel_ok && (int'(sel) == i);

            // A put on this channel preempts the tick entirely, including expiry.
            if (put && hit[i]) begin
                count_d[i]  = value;
                reload_d[i] = value;
            end else if (tick && en_q[i] && (count_q[i] > W'(1))) begin
                count_d[i] = count_q[i] - W'(1);
            end else if (tick && en_q[i] && (count_q[i] == W'(1))) begin
                expire[i] = 1'b1;
                if (per_q[i]) begin
                    count_d[i] = reload_q[i];
                end else begin
                    count_d[i] = '0;
                    en_d[i]    = 1'b0;
                end
            end

            if (ack && hit[i]) begin
                flag_d[i] = 1'b0;
            end
            if (expire[i]) begin
                flag_d[i] = 1'b1;
            end

            // An explicit cfg write overrides the one-shot auto-disable.
            if (cfg && hit[i]) begin
                en_d[i]  = mode_in[1];
                per_d[i] = mode_in[0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q  <= div;
            en_q   <= '0;
            per_q  <= '0;
            flag_q <= '0;
            for (int i = 0; i < N; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            en_q   <= en_d;
            per_q  <= per_d;
            flag_q <= flag_d;
            for (int i = 0; i < N; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
        end
    end

    assign rdata = sel_ok ? count_q[sel] : '0;
    assign flags = flag_q;
    assign irq   = |flag_q;

endmodule

// File: tb/tb_countdown_bank.sv
// Self-checking bench for countdown_bank: directed scenarios plus randomized traffic vs a reference model.
module tb_countdown_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] div = 8'd0;
    logic [1:0] sel = 2'd0;
    logic [7:0] value = 8'd0;
    logic       put = 1'b0;
    logic       cfg = 1'b0;
    logic [1:0] mode_in = 2'd0;
    logic       ack = 1'b0;
    logic [7:0] rdata;
    logic [3:0] flags;
    logic       irq;

    int checks = 0;
    int errors = 0;

    int m_cnt [4];
    int m_rel [4];
    bit m_en  [4];
    bit m_per [4];
    bit m_flag[4];
    int m_cyc;
    int m_div;

    countdown_bank #(.W(8), .N(4), .P(8), .S(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .div    (div),
        .sel    (sel),
        .value  (value),
        .put    (put),
        .cfg    (cfg),
        .mode_in(mode_in),
        .ack    (ack),
        .rdata  (rdata),
        .flags  (flags),
        .irq    (irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: tick is a pure function of cycles since reset.
    task automatic model_edge();
        bit t;
        bit h;
        bit ex;
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                m_cnt[c] = 0; m_rel[c] = 0; m_en[c] = 0; m_per[c] = 0; m_flag[c] = 0;
            end
            m_cyc = 0;
            m_div = int'(div);
        end else begin
            t = ((m_cyc % (m_div + 1)) == m_div);
            m_cyc++;
            for (int c = 0; c < 4; c++) begin
                h  = (int'(sel) == c);
                ex = 0;
                if (put && h) begin
                    m_cnt[c] = int'(value);
                    m_rel[c] = int'(value);
                end else if (t && m_en[c] && m_cnt[c] != 0) begin
                    if (m_cnt[c] > 1) begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end else begin
                        ex = 1;
                        if (m_per[c]) m_cnt[c] = m_rel[c];
                        else begin
                            m_cnt[c] = 0;
                            m_en[c]  = 0;
                        end
                    end
                end
                if (ack && h) m_flag[c] = 0;
                if (ex) m_flag[c] = 1;
                if (cfg && h) begin
                    m_en[c]  = mode_in[1];
                    m_per[c] = mode_in[0];
                end
            end
        end
    endtask

    function automatic logic [3:0] model_flags();
        logic [3:0] f;
        for (int c = 0; c < 4; c++) f[c] = m_flag[c];
        return f;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        chk("model_rdata", 32'(rdata), 32'(m_cnt[sel]));
        chk("model_flags", 32'(flags), 32'(model_flags()));
        chk("model_irq", 32'(irq), 32'(|model_flags()));
        put = 1'b0;
        cfg = 1'b0;
        ack = 1'b0;
    endtask

    task automatic do_reset(input logic [7:0] d);
        reset = 1'b1;
        div   = d;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input logic [1:0] ch, input logic [7:0] v, input logic [1:0] m);
        sel = ch; value = v; put = 1'b1; cfg = 1'b1; mode_in = m;
        step();
    endtask

    initial begin
        int exp_cnt[9];
        int exp_fl[9];
        int exp_f39[6];

        // One-shot countdown, div = 0
        do_reset(8'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        load(2'd1, 8'd3, 2'b10);
        chk("oneshot_3", 32'(rdata), 32'd3);
        step(); chk("oneshot_2", 32'(rdata), 32'd2);
        step(); chk("oneshot_1", 32'(rdata), 32'd1);
        step(); chk("oneshot_0", 32'(rdata), 32'd0);
        chk("oneshot_flag", 32'(flags), 32'b0010);
        step(); chk("oneshot_hold", 32'(rdata), 32'd0);
        sel = 2'd1; value = 8'd2; put = 1'b1;
        step(); step();
        chk("oneshot_disabled", 32'(rdata), 32'd2);

        // Periodic, div = 1: expiry every 4 clocks
        do_reset(8'd1);
        load(2'd0, 8'd2, 2'b11);
        exp_cnt = '{0, 1, 1, 2, 2, 1, 1, 2, 2};
        exp_fl  = '{0, 0, 0, 1, 0, 0, 0, 1, 1};
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin sel = 2'd0; ack = 1'b1; end
            step();
            chk("periodic_cnt", 32'(rdata), 32'(exp_cnt[k]));
            chk("periodic_flag", 32'(flags), 32'(exp_fl[k]));
            chk("periodic_irq", 32'(irq), 32'(exp_fl[k]));
        end

        // Set beats ack on the same edge
        do_reset(8'd0);
        load(2'd2, 8'd2, 2'b10);
        step();
        sel = 2'd2; ack = 1'b1;
        step();
        chk("collision_flag", 32'(flags[2]), 32'd1);

        // Put beats the expiring tick
        load(2'd0, 8'd1, 2'b10);
        sel = 2'd0; value = 8'd9; put = 1'b1;
        step();
        chk("priority_cnt", 32'(rdata), 32'd9);
        chk("priority_flag", 32'(flags[0]), 32'd0);

        // Independence while ch1 config toggles
        do_reset(8'd0);
        exp_f39 = '{0, 0, 0, 0, 1, 9};
        load(2'd3, 8'd5, 2'b11);
        load(2'd0, 8'd3, 2'b11);
        for (int k = 2; k <= 5; k++) begin
            sel = 2'd1; cfg = 1'b1; mode_in = 2'($urandom_range(0, 3));
            step();
            chk("indep_flags", 32'(flags), 32'(exp_f39[k]));
        end

        // Reset mid-run, then first tick after div+1 clocks
        load(2'd2, 8'd7, 2'b11);
        reset = 1'b1; div = 8'd2;
        step();
        for (int c = 0; c < 4; c++) begin
            sel = 2'(c);
            #1;
            chk("midreset_rdata", 32'(rdata), 32'd0);
        end
        chk("midreset_flags", 32'(flags), 32'd0);
        chk("midreset_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        load(2'd0, 8'd2, 2'b10);
        chk("firsttick_c0", 32'(rdata), 32'd2);
        step(); chk("firsttick_c1", 32'(rdata), 32'd2);
        step(); chk("firsttick_c2", 32'(rdata), 32'd1);

        // Randomized traffic against the model
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(8'($urandom_range(0, 3)));
            for (int n = 0; n < 300; n++) begin
                sel     = 2'($urandom_range(0, 3));
                value   = 8'($urandom_range(0, 6));
                mode_in = 2'($urandom_range(0, 3));
                put     = ($urandom_range(0, 9) == 0);
                cfg     = ($urandom_range(0, 5) == 0);
                ack     = ($urandom_range(0, 5) == 0);
                reset   = ($urandom_range(0, 199) == 0);
                step();
                reset   = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_bank.md
COUNTDOWN_BANK -- requirements
Module: countdown_bank

Interface
REQ-001 Parameter W, default 8, width of every channel counter and reload register.
REQ-002 Parameter N, default 4, channel count (N >= 2).
REQ-003 Parameter P, default 8, prescaler width.
REQ-004 Parameter S, default 2, channel-select width (2**S >= N).
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 div  input  P  prescaler divisor; one tick every div+1 clocks.
REQ-008 sel  input  S  channel addressed by put, cfg, ack and rdata.
REQ-009 value  input  W  load data for put.
REQ-010 put  input  1  load count[sel] and reload[sel] with value.
REQ-011 cfg  input  1  write enable[sel] <= mode_in[1], periodic[sel] <= mode_in[0].
REQ-012 mode_in  input  2  configuration data for cfg.
REQ-013 ack  input  1  clear flag[sel].
REQ-014 rdata  output  W  count[sel], combinational.
REQ-015 flags  output  N  per-channel sticky expiry flags, registered.
REQ-016 irq  output  1  OR of flags, combinational.

Function
REQ-017 The prescaler SHALL tick in the cycle its counter is 0, reload from div on that cycle, and otherwise decrement by 1.
REQ-018 div = 0 SHALL give a tick on every clock.
REQ-019 On a tick, each channel with enable = 1 and count > 1 SHALL decrement by 1.
REQ-020 On a tick, an enabled channel with count = 1 SHALL set its flag; periodic = 1: count <= reload; periodic = 0: count <= 0 and enable <= 0.
REQ-021 A channel with count = 0 SHALL hold and SHALL NOT set its flag.
REQ-022 A periodic channel SHALL therefore flag once every reload ticks; reload = 0 SHALL stop it at 0.
REQ-023 A channel with enable = 0 SHALL hold its count regardless of ticks.
REQ-024 Per-channel priority SHALL be: reset > put > tick decrement.
REQ-025 put SHALL take effect on the next edge and SHALL NOT change enable, periodic or flag.
REQ-026 cfg on the same cycle as put SHALL also apply, to the same channel.
REQ-027 When a flag set and ack hit the same channel in one cycle, the set SHALL win.
REQ-028 put, cfg and ack SHALL affect only channel sel; sel >= N SHALL be ignored, with rdata = 0.
REQ-029 Channels SHALL be independent: a strobe on one channel SHALL NOT disturb the tick behaviour of the others.
REQ-030 Counter arithmetic SHALL be unsigned modulo 2**W and SHALL never wrap below 0.

Reset
REQ-031 reset SHALL clear every count, reload, enable, periodic and flag to 0.
REQ-032 reset SHALL load the prescaler counter with div, so the first tick occurs div+1 clocks after reset deasserts.
REQ-033 After reset, rdata = 0, flags = 0 and irq = 0.
REQ-034 reset asserted mid-count SHALL abort every channel on the same edge, with no flag set.

Verification
REQ-035 One-shot: div = 0; put ch1 value = 3; cfg ch1 mode = 10 -> rdata 3,2,1,0 on successive clocks; flags[1] = 1 with count reaching 0; enable cleared; count stays 0.
REQ-036 Periodic: div = 1; ch0 value = 2, mode = 11 -> flags[0] set every 4 clocks, count cycling 2,1,2,1; ack clears the flag and irq falls.
REQ-037 Collision: ack on ch2 in the cycle ch2 expires -> flags[2] remains 1.
REQ-038 Priority: put ch0 value = 9 in the cycle ch0 counts 1 -> 0 -> count = 9, no flag set.
REQ-039 Independence: ch0 and ch3 run with different values while cfg toggles ch1 -> ch0 and ch3 expire on their expected clocks.
REQ-040 Reset mid-run: reset asserted with three channels active -> all counts and flags are 0 on the next clock; first tick occurs div+1 clocks after reset deasserts.
